// File: rtl/gate_truth_seq.sv
// gate_truth_seq: clocked truth-table sequencer for 2-input gate exercises.
// Drives gate_a/gate_b through 00, 01, 10, 11. Each vector is held for
// HOLD_CYCLES settle cycles and then one SAMPLE cycle. In SAMPLE the block
// checks and_in/or_in against a&b and a|b and adds the mismatches to a
// saturating error count. At the end of the run it reports done and pass.
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst_n    in   1      async active-low reset
//   start    in   1      run request, accepted only when idle or done
//   and_in   in   1      and_gate output under test
//   or_in    in   1      or_gate output under test
//   gate_a   out  1      gate input A
//   gate_b   out  1      gate input B
//   vec_idx  out  2      current vector index = {gate_a, gate_b}
//   busy     out  1      run in progress (DRIVE/SAMPLE)
//   done     out  1      run finished
//   pass     out  1      valid while done; 1 when err_cnt == 0
//   err_cnt  out  CNT_W  saturating mismatch count
module gate_truth_seq #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             and_in,
    input  logic             or_in,
    output logic             gate_a,
    output logic             gate_b,
    output logic [1:0]       vec_idx,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned HW = $clog2(HOLD_CYCLES) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    state_t          state;
    logic [HW-1:0]   hold_cnt;
    logic [1:0]      err_inc;
    logic [CNT_W:0]  err_sum;
    logic [CNT_W-1:0] err_sat;

    // Per-vector mismatch count (0..2) and the saturating accumulation.
    always_comb begin
        err_inc = '0;
        err_inc = {1'b0, (and_in != (gate_a & gate_b))}
                + {1'b0, (or_in  != (gate_a | gate_b))};
        err_sum = {1'b0, err_cnt} + (CNT_W + 1)'(err_inc);
        err_sat = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            gate_a   <= 1'b0;
            gate_b   <= 1'b0;
            vec_idx  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= DRIVE;
                        hold_cnt <= '0;
                        vec_idx  <= '0;
                        err_cnt  <= '0;
                        gate_a   <= 1'b0;
                        gate_b   <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    err_cnt <= err_sat;
                    if (vec_idx == 2'd3) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        gate_a <= 1'b0;
                        gate_b <= 1'b0;
                    end else begin
                        state    <= DRIVE;
                        hold_cnt <= '0;
                        vec_idx  <= vec_idx + 2'd1;
                        gate_a   <= (vec_idx == 2'd1) || (vec_idx == 2'd2);
                        gate_b   <= ~vec_idx[0];
                    end
                end
                DONE: begin
                    // The first DONE cycle publishes done/pass from the final
                    // err_cnt. That count was registered on the last SAMPLE
                    // edge, so done rises one edge after the run ends. A
                    // restart is taken only once done is visible.
                    if (!done) begin
                        done <= 1'b1;
                        pass <= (err_cnt == '0);
                    end else if (start) begin
                        state    <= DRIVE;
                        hold_cnt <= '0;
                        vec_idx  <= '0;
                        err_cnt  <= '0;
                        gate_a   <= 1'b0;
                        gate_b   <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_seq.sv
module tb_gate_truth_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       and_in, or_in, gate_a, gate_b, busy, done, pass;
    logic [1:0] vec_idx;
    logic [3:0] err_cnt;
    int unsigned mode = 0;

    logic       start2 = 1'b0;
    logic       and2, or2, ga2, gb2, busy2, done2, pass2;
    logic [1:0] vec2;
    logic [1:0] err2;
    int unsigned mode2 = 3;

    int compared = 0;
    int mismatched = 0;

    logic [1:0] vec_q[$];
    logic [4:0] res_q[$];

    always #5 clk = ~clk;

    // Gate models. 0 = ideal, 1 = and stuck at 0, 2 = swapped, 3 = inverted.
    function automatic logic f_and(input int unsigned m, input logic a, input logic b);
        case (m)
            0: return a & b;
            1: return 1'b0;
            2: return a | b;
            default: return ~(a & b);
        endcase
    endfunction

    function automatic logic f_or(input int unsigned m, input logic a, input logic b);
        case (m)
            0, 1: return a | b;
            2: return a & b;
            default: return ~(a | b);
        endcase
    endfunction

    assign and_in = f_and(mode, gate_a, gate_b);
    assign or_in  = f_or(mode, gate_a, gate_b);
    assign and2   = f_and(mode2, ga2, gb2);
    assign or2    = f_or(mode2, ga2, gb2);

    gate_truth_seq #(.HOLD_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .and_in(and_in), .or_in(or_in),
        .gate_a(gate_a), .gate_b(gate_b), .vec_idx(vec_idx), .busy(busy),
        .done(done), .pass(pass), .err_cnt(err_cnt)
    );

    gate_truth_seq #(.HOLD_CYCLES(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .and_in(and2), .or_in(or2),
        .gate_a(ga2), .gate_b(gb2), .vec_idx(vec2), .busy(busy2),
        .done(done2), .pass(pass2), .err_cnt(err2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One run on dut. Expected vectors and the final result are queued when
    // start is driven, then popped as the DUT presents each vector and done.
    task automatic run_seq(input int unsigned m, input logic [3:0] e_err,
                           input logic e_pass, input bit hold_start);
        int unsigned k;
        bit seen;
        logic [1:0] v;
        logic [4:0] r;
        mode = m;
        for (int i = 0; i < 4; i++) vec_q.push_back(2'(i));
        res_q.push_back({e_err, e_pass});
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        seen = 1'b0;
        k = 0;
        v = '0;
        while (k < 40 && !seen) begin
            @(negedge clk);
            if (k < 12) begin
                if (k % 3 == 0) begin
                    v = vec_q.pop_front();
                    check("vec_idx", 32'(vec_idx), 32'(v));
                    check("gate_ab", 32'({gate_a, gate_b}), 32'(v));
                    check("busy_run", 32'(busy), 1);
                end else begin
                    check("vec_hold", 32'(vec_idx), 32'(v));
                end
            end
            if (done) begin
                seen = 1'b1;
                check("done_edge", k, 13);
            end else begin
                k++;
            end
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
        end else begin
            r = res_q.pop_front();
            check("err_cnt", 32'(err_cnt), 32'(r[4:1]));
            check("pass", 32'(pass), 32'(r[0]));
            check("busy_done", 32'(busy), 0);
            check("vec_done", 32'(vec_idx), 3);
            check("gate_done", 32'({gate_a, gate_b}), 0);
        end
    endtask

    initial begin
        int unsigned n;
        int unsigned pulses;
        bit seen;

        // Reset state
        #2;
        check("rst_outs", 32'({gate_a, gate_b, vec_idx, busy, done, pass, err_cnt}), 0);
        check("rst_outs2", 32'({ga2, gb2, vec2, busy2, done2, pass2, err2}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        // Ideal gates
        run_seq(0, 4'd0, 1'b1, 1'b0);
        // and stuck at 0, restarted directly from DONE
        run_seq(1, 4'd1, 1'b0, 1'b0);
        // swapped outputs
        run_seq(2, 4'd4, 1'b0, 1'b0);

        // start held high: one run, then restart from DONE on the next edge
        run_seq(1, 4'd1, 1'b0, 1'b1);
        @(negedge clk);
        check("restart_done", 32'(done), 0);
        check("restart_busy", 32'(busy), 1);
        check("restart_err", 32'(err_cnt), 0);
        check("restart_vec", 32'(vec_idx), 0);
        start = 1'b0;

        // Reset in the middle of DRIVE for vector 2
        do_reset();
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (n < 20 && !(vec_idx == 2'd2 && busy)) begin
            @(negedge clk);
            n++;
        end
        check("reach_vec2", 32'(vec_idx), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 32'({gate_a, gate_b, vec_idx, busy, done, pass, err_cnt}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("no_done_after_abort", pulses, 0);

        // Saturation on the CNT_W=2 instance
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        seen = 1'b0;
        n = 0;
        while (n < 40 && !seen) begin
            @(negedge clk);
            if (done2) seen = 1'b1;
            n++;
        end
        check("done2_seen", 32'(seen), 1);
        check("err_sat", 32'(err2), 3);
        check("pass_sat", 32'(pass2), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
